// File: rtl/seq_stream_scanner_pkg.sv
// Shared types and reset defaults for the stream scanner and its bit matcher.
package seq_stream_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the per-bit length mask; equals the default maximum pattern length.
    localparam int MASK_W = 5;

    localparam logic [MASK_W-1:0] DEFAULT_PAT = 5'b10110;
    localparam int                DEFAULT_LEN = 5;

endpackage

// File: rtl/seq_stream_scanner_pattern_matcher.sv
// Serial matcher: shift history plus fill count; match registered one cycle after the completing bit.
// No backpressure: consumes one bit on every cycle bit_valid is high.
module pattern_matcher
    import seq_stream_scanner_pkg::*;
#(
    parameter int PAT_W = MASK_W,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             serial_bit,
    input  logic             clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [PAT_W-1:0]  mask;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              len_ok;
    logic              hit;

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], serial_bit};
        fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        len_ok = (len != '0) && (int'(len) <= PAT_W);
        // Only the newest len bits take part; older history is masked off.
        hit = bit_valid && len_ok && (int'(fill_nxt) >= int'(len))
              && (((hist_nxt ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (bit_valid) begin
                hist <= hist_nxt;
                fill <= fill_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_stream_scanner.sv
// Word-to-bit serializer feeding a programmable pattern matcher with a saturating match counter.
// First bit enters the matcher the cycle after accept; in_ready only in IDLE or on the final bit of a non-last word.
module seq_stream_scanner
    import seq_stream_scanner_pkg::*;
#(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = MASK_W,
    parameter int               LEN_W   = 3,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_DEF = DEFAULT_PAT,
    parameter int               LEN_DEF = DEFAULT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              clr_count,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic              last_q;
    logic [PAT_W-1:0]  pat_q;
    logic [LEN_W-1:0]  len_q;
    logic              last_bit;
    logic              accept;
    logic              bit_valid;
    logic              match;

    assign last_bit = (bit_cnt == '0);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bit_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                // Reloading on the final bit keeps a continuous stream bubble-free.
                in_ready  = last_bit && !last_q;
                if (last_bit && !(in_valid && !last_q)) begin
                    state_nxt = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            pat_q   <= PAT_DEF;
            len_q   <= LEN_W'(LEN_DEF);
        end else begin
            if (accept) begin
                shreg   <= in_data;
                bit_cnt <= BC_W'(WORD_W - 1);
                last_q  <= in_last;
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - BC_W'(1);
            end
            // Config only changes between streams so a word never sees two patterns.
            if (cfg_we && (state == IDLE)) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
            end
        end
    end

    pattern_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .serial_bit (shreg[WORD_W-1]),
        .clear      (state == DONE),
        .pattern    (pat_q),
        .len        (len_q),
        .match      (match)
    );

    assign match_pulse = match;

    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            match_count <= '0;
        end else if (match && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_stream_scanner.sv
// Bench for seq_stream_scanner: directed cases plus random streams against a sliding-window model.
module tb_seq_stream_scanner;

    localparam logic [4:0] PAT_DEF = 5'b10110;
    localparam int         LEN_DEF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       clr_count = 1'b0;

    logic       in_ready, match_pulse, busy, done;
    logic [7:0] match_count;
    logic       in_ready2, match_pulse2, busy2, done2;
    logic [1:0] match_count2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_q[$];
    int done_q[$];
    int acc_q[$];
    int exp_q[$];
    logic [7:0] words[$];
    logic [4:0] m_pat = PAT_DEF;
    int m_len = LEN_DEF;
    int m_cnt = 0;

    seq_stream_scanner #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .clr_count(clr_count), .match_pulse(match_pulse), .match_count(match_count),
        .busy(busy), .done(done)
    );

    seq_stream_scanner #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .clr_count(clr_count), .match_pulse(match_pulse2), .match_count(match_count2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (match_pulse === 1'b1) pulse_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
    end

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [4:0] p, input int l);
        cfg_we = 1'b1;
        cfg_pattern = p;
        cfg_len = 3'(l);
        @(negedge clk); #1;
        cfg_we = 1'b0;
        m_pat = p;
        m_len = l;
    endtask

    // Expected pulse offsets (cycles after accept) from a plain sliding window over the stream's bits.
    task automatic build_exp(input int clr_off);
        int bits[$];
        int kept;
        exp_q = {};
        foreach (words[k]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(int'(words[k][b]));
        end
        for (int i = 0; i < bits.size(); i++) begin
            bit ok;
            ok = (m_len >= 1) && (m_len <= 5) && (i + 1 >= m_len);
            for (int j = 0; j < m_len && ok; j++) begin
                if (bits[i-j] != int'(m_pat[j])) ok = 1'b0;
            end
            if (ok) exp_q.push_back(i + 2);
        end
        kept = 0;
        foreach (exp_q[i]) if (exp_q[i] > clr_off) kept++;
        m_cnt = ((clr_off >= 0) ? 0 : m_cnt) + kept;
    endtask

    task automatic run_stream(input string tag, input int clr_off, input int cfg_off,
                              input bit cfg_same, input logic [4:0] npat, input int nlen);
        int k;
        int guard;
        logic acc;
        k = 0;
        guard = 0;
        pulse_q = {};
        done_q = {};
        acc_q = {};
        if (cfg_same) begin
            m_pat = npat;
            m_len = nlen;
        end
        build_exp(clr_off);
        while (k < words.size() && guard < 100) begin
            in_valid = 1'b1;
            in_data = words[k];
            in_last = (k == words.size() - 1);
            cfg_we = cfg_same && (k == 0);
            cfg_pattern = npat;
            cfg_len = 3'(nlen);
            acc = in_ready;
            if (acc) acc_q.push_back(cyc);
            @(negedge clk); #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        cfg_we = 1'b0;
        guard = 0;
        while (done_q.size() == 0 && guard < 100) begin
            clr_count = (acc_q.size() > 0) && (cyc - acc_q[0] == clr_off);
            if ((acc_q.size() > 0) && (cyc - acc_q[0] == cfg_off)) begin
                cfg_we = 1'b1;
                cfg_pattern = 5'b00011;
                cfg_len = 3'd2;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk); #1;
            guard++;
        end
        clr_count = 1'b0;
        cfg_we = 1'b0;
        chk({tag, " accepts"}, acc_q.size(), words.size());
        for (int i = 1; i < acc_q.size(); i++) chk({tag, " accept spacing"}, acc_q[i] - acc_q[i-1], 8);
        chk({tag, " done count"}, done_q.size(), 1);
        if (acc_q.size() > 0 && done_q.size() > 0)
            chk({tag, " done offset"}, done_q[0] - acc_q[0], 8 * words.size() + 1);
        chk({tag, " pulse count"}, pulse_q.size(), exp_q.size());
        for (int i = 0; i < pulse_q.size() && i < exp_q.size() && acc_q.size() > 0; i++)
            chk({tag, " pulse offset"}, pulse_q[i] - acc_q[0], exp_q[i]);
        @(negedge clk); #1;
        chk({tag, " count"}, match_count, sat(m_cnt, 255));
        chk({tag, " count2"}, match_count2, sat(m_cnt, 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst match_pulse", match_pulse, 0);
        chk("rst count", match_count, 0);
        chk("rst count2", match_count2, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1);
        chk("post-rst in_ready2", in_ready2, 1);

        words = {8'b10110110};
        run_stream("single", -1, -1, 0, 0, 0);
        words = {8'b00000101, 8'b10000000};
        run_stream("b2b", -1, -1, 0, 0, 0);
        words = {8'b00001011};
        run_stream("bound1", -1, -1, 0, 0, 0);
        words = {8'b00000000};
        run_stream("bound2", -1, -1, 0, 0, 0);
        words = {8'b10110110};
        run_stream("saturate", -1, -1, 0, 0, 0);
        run_stream("clear", 6, -1, 0, 0, 0);

        set_cfg(5'b00101, 3);
        words = {8'b10101010};
        run_stream("cfg len3", -1, -1, 0, 0, 0);
        set_cfg(PAT_DEF, LEN_DEF);
        words = {8'b10110110};
        run_stream("cfg in shift", -1, 3, 0, 0, 0);
        set_cfg(PAT_DEF, 0);
        run_stream("len0", -1, -1, 0, 0, 0);

        // Abort mid-stream with a non-default config active.
        set_cfg(5'b00101, 3);
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_last = 1'b1;
        chk("abort accept", in_ready, 1);
        @(negedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        chk("abort busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort in_ready low", in_ready, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        done_q = {};
        m_pat = PAT_DEF;
        m_len = LEN_DEF;
        m_cnt = 0;
        chk("abort in_ready", in_ready, 1);
        chk("abort busy idle", busy, 0);
        chk("abort count", match_count, 0);
        chk("abort count2", match_count2, 0);
        repeat (12) begin @(negedge clk); #1; end
        chk("abort no done", done_q.size(), 0);
        words = {8'b10110110};
        run_stream("after abort", -1, -1, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            int nw;
            nw = $urandom_range(1, 3);
            words = {};
            for (int i = 0; i < nw; i++) words.push_back(8'($urandom));
            run_stream("random", -1, -1, 1, 5'($urandom), int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_stream_scanner.md
Name: seq_stream_scanner

Overview:
- Controller that takes parallel words over a valid/ready handshake and serializes them MSB-first into an internal programmable bit-pattern matcher.
- Counts matches, including overlapping ones, and reports end-of-stream.
- Sits between a word-oriented producer and the serial pattern-detection function.
- The target pattern and its length are runtime-configurable; reset loads the default pattern 10110.

Parameters:
- WORD_W, 8, input word width in bits.
- PAT_W, 5, maximum pattern length in bits.
- LEN_W, 3, width of the pattern-length field (must hold PAT_W).
- CNT_W, 8, match counter width.
- PAT_DEF, 5'b10110, pattern loaded at reset.
- LEN_DEF, 5, pattern length loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern bits; the pattern occupies the low cfg_len bits, and its MSB is the first bit in time.
- cfg_len  in  LEN_W  pattern length; 0 or >PAT_W disables matching.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WORD_W  input word, shifted out MSB first.
- in_last  in  1  marks the final word of a stream.
- clr_count  in  1  synchronous clear of match_count.
- match_pulse  out  1  one-cycle pulse per match.
- match_count  out  CNT_W  saturating match total.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse at end of stream.

Behaviour:
- Reset values:
  - match_pulse=0, match_count=0, busy=0, done=0.
  - in_ready=0 during reset; it is 1 from the first cycle after reset.
  - Internal state: state=IDLE, history and history fill count cleared, pattern=PAT_DEF, len=LEN_DEF.
  - rst mid-stream aborts immediately. The partial word is discarded and no done is produced.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: load shreg<=in_data, last_q<=in_last, bit_cnt<=WORD_W-1, go to SHIFT.
    - cfg_we latches pattern/len. If cfg_we and a word handshake occur in the same cycle, both take effect, and the new config governs that word.
  - SHIFT:
    - Each cycle, shreg MSB enters the matcher, shreg shifts left, and bit_cnt decrements.
    - in_ready = (bit_cnt==0)&&!last_q. An accept on that cycle reloads shreg and bit_cnt and stays in SHIFT, giving zero-bubble streaming of 1 word per WORD_W cycles.
    - On bit_cnt==0 with no accept: go to DONE if last_q, else to IDLE.
    - cfg_we is ignored.
  - DONE:
    - done=1 for exactly one cycle, then go to IDLE.
    - History and fill count are cleared, so matches never span streams.
- Matcher:
  - hist <= {hist[PAT_W-2:0], bit}.
  - fill count saturates at PAT_W.
  - A match occurs on a bit when fill (including that bit) >= len and the low len bits of the updated hist equal the low len bits of pattern.
  - match_pulse is registered: it is high the cycle after the completing bit is shifted in.
  - Overlapping matches are all counted.
  - If len==0 or len>PAT_W, matching is disabled.
  - The history is not cleared between words of the same stream.
- Counter:
  - match_count increments with each match_pulse and saturates at 2^CNT_W-1.
  - If clr_count and an increment coincide, clear wins: the count becomes 0 and that match is lost. match_pulse still fires.
  - Counter and pattern survive DONE; only rst resets them.
- Latency: the first bit of an accepted word enters the matcher on the cycle after acceptance.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - PAT_DEF/LEN_DEF defaults;
  - a helper constant for the width of the length mask.
- One sub-module is natural: pattern_matcher.
  - Holds hist, fill and the compare logic, and produces a registered match.
  - Inputs: bit_valid, bit, clear, pattern, len.
- Serializer, FSM, handshake and counter stay in the top.

Test Plan:
- Default config; single word 8'b10110110 with in_last=1 -> two match_pulses (after bits 5 and 8), match_count=2, done pulses once 9 cycles after accept.
- Back-to-back words 8'b00000101 then 8'b10000000 (last), in_valid held high:
  - second word accepted on the first word's bit_cnt==0 cycle with no bubble;
  - one cross-boundary match; match_count=1.
- Stream boundary: 8'b00001011 with last=1, then a new stream 8'b00000000 last=1 -> no match (history cleared at DONE); count unchanged.
- Configuration:
  - In IDLE write pattern=5'b00101, len=3, then send 8'b10101010 -> 3 matches.
  - A cfg_we pulsed during SHIFT is ignored; the bench checks the old pattern still applies.
  - len=0 -> 0 matches.
- Saturation and clear:
  - With CNT_W=2, stream 8'b10110110 twice -> count saturates at 3.
  - clr_count asserted on a match cycle -> count=0.
- rst asserted mid-SHIFT -> next cycle: state IDLE, in_ready=1, no done, count=0, pattern=10110.
